matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The module SHALL have the following ports:
  clk  input  1  system clock; all state updates on the rising edge
  rst_n  input  1  asynchronous active-low reset
  start  input  1  request to begin a new matrix load; sampled only in IDLE
  matrix_size  input  2  00=2x2, 01=3x3, 10=4x4, 11=5x5; sampled with start
  in_valid  input  1  in_data carries a valid element this cycle
  in_data  input  8  signed element, row-major order, two's complement
  in_ready  output  1  loader accepts an element this cycle
  matrix_A  output  200  signed packed 5x5 matrix, 8 bits per element
  busy  output  1  load in progress (LOAD or DONE state)
  done  output  1  one-cycle pulse: matrix_A complete and valid
REQ-002 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Element (r,c) SHALL occupy matrix_A[(r*5+c)*8 +: 8], with r,c in 0..4, regardless of size.

Function
REQ-004 The FSM SHALL have three states: IDLE, LOAD, DONE.
REQ-005 In IDLE with start=1, the module SHALL do the following on that edge:
  - latch matrix_size as N (2..5)
  - clear matrix_A to 0
  - clear row and column counters r,c to 0
  - enter LOAD
REQ-006 start SHALL be ignored in LOAD and DONE; matrix_size changes after the start edge SHALL be ignored.
REQ-007 in_ready SHALL be 1 only in LOAD; it SHALL be combinationally derived from state alone, never from in_valid.
REQ-008 An element SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL then be written at (r,c).
REQ-009 Counter advance on each acceptance:
  - if c<N-1, c increments
  - otherwise c returns to 0 and r increments
REQ-010 Cycles with in_valid=0 in LOAD SHALL change no state; gaps of any length are legal.
REQ-011 Acceptance of element (N-1,N-1) SHALL move the FSM to DONE; exactly N*N elements are accepted per load.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-013 Latency: done SHALL be asserted in the cycle immediately after the edge that accepts the last element.
REQ-014 Positions with r>=N or c>=N SHALL read 0 at done and thereafter.
REQ-015 matrix_A SHALL be registered; its value SHALL hold from done until the next accepted start.
REQ-016 During LOAD, matrix_A SHALL show the partially written matrix; consumers SHALL use it only at or after done.
REQ-017 busy SHALL be 1 in LOAD and DONE and 0 in IDLE.
REQ-018 in_data SHALL be stored bit-exact; no sign extension or saturation SHALL occur.
REQ-019 start asserted in the DONE cycle SHALL be ignored; a new load requires start while in IDLE.

Reset
REQ-020 On rst_n=0, the module SHALL immediately, independent of clk, apply the following:
  - state=IDLE
  - r=c=0, N=2
  - matrix_A=0
  - in_ready=0, busy=0, done=0
REQ-021 A reset asserted mid-load SHALL discard partial data; after release, the module SHALL wait in IDLE for start.
REQ-022 Leaving reset SHALL require no extra cycles; start on the first edge after rst_n rises SHALL be honoured.

Verification
REQ-023 Bench scenario, 2x2 basic: start with size=00, then elements 1,2,3,4 with in_valid continuously high.
  - matrix_A[7:0]=1, [15:8]=2, [47:40]=3, [55:48]=4; all other bits 0
  - done pulses once, one cycle after the 4th acceptance
REQ-024 Bench scenario, 5x5 with gaps: start with size=11, then elements 0..24 with random in_valid gaps.
  - byte k equals k for k=0..24
  - exactly 25 acceptances; in_ready drops after the last
REQ-025 Bench scenario, signed data: 3x3 load of -128,127,-1,0,1,2,3,4,5.
  - bytes at positions 0,1,2 = 0x80, 0x7F, 0xFF
  - bytes at positions 3,4,8,9,13,14 and 15..24 = 0
REQ-026 Bench scenario, reset mid-load: 4x4 load, rst_n pulsed low after 7 elements.
  - matrix_A=0, busy=0, in_ready=0 asynchronously
  - a following 2x2 load completes correctly
REQ-027 Bench scenario, ignored start and back-to-back loads: start pulsed during LOAD and during DONE; then a 5x5 load of all 0x11, then a 2x2 load of 9,9,9,9.
  - the pulsed starts cause no restart
  - after the second done: bytes 0,1,5,6 = 9 and all others 0

Source files
------------

// File: rtl/matrix_loader.sv
// Loads an NxN (N = 2..5) matrix of signed bytes, streamed in row-major order,
// into a registered 5x5 packed array; unused rows and columns stay zero.
module matrix_loader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   matrix_size,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [199:0] matrix_A,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] size_q;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] last_idx;
    logic       accept;
    logic       last_elem;
    logic [7:0] base;

    // size code 00..11 maps to N-1 = 1..4
    assign last_idx  = {1'b0, size_q} + 3'd1;
    assign accept    = in_valid && (state == LOAD);
    assign last_elem = accept && (row == last_idx) && (col == last_idx);
    assign base      = ({5'd0, row} * 8'd5 + {5'd0, col}) * 8'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_elem)
                    next_state = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Clearing the whole matrix on start is what keeps the rows and columns
    // beyond N at zero for smaller sizes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q   <= 2'b00;
            row      <= 3'd0;
            col      <= 3'd0;
            matrix_A <= '0;
        end else if (state == IDLE && start) begin
            size_q   <= matrix_size;
            row      <= 3'd0;
            col      <= 3'd0;
            matrix_A <= '0;
        end else if (accept) begin
            matrix_A[base +: 8] <= in_data;
            if (col == last_idx) begin
                col <= 3'd0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

endmodule
